// File: rtl/down_counter_timer_pkg.sv
// down_counter_timer_pkg: shared counter-library types and Gray-code helpers.
// Rev 1.0
`default_nettype none

package down_counter_timer_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Fixed 32-bit datapath; callers zero-extend and truncate to their width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter / timer with one-shot and auto-reload
// modes, registered terminal-count pulse and registered Gray copy of the count. Rev 1.0
`default_nettype none

module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             reload_mode,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             busy
);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;
  logic             mode_reg;
  logic             mode_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] gray_next;
  logic             tc_next;

  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN);

  always_comb begin
    state_next  = state;
    reload_next = reload_reg;
    mode_next   = mode_reg;
    count_next  = count_out;
    tc_next     = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid) begin
          reload_next = load_value;
          mode_next   = reload_mode;
          count_next  = load_value;
          // A zero load expires immediately without ever entering RUN.
          if (load_value != '0) state_next = RUN;
          else                  tc_next    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (enable) begin
          if (count_out > WIDTH'(1)) begin
            count_next = count_out - WIDTH'(1);
          end else begin
            tc_next = 1'b1;
            if (mode_reg) begin
              count_next = reload_reg;
            end else begin
              count_next = '0;
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gray is taken from the next binary value so both outputs change on one edge.
  assign gray_next = WIDTH'(bin2gray(GRAY_MAX_W'(count_next)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      count_out  <= '0;
      count_gray <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_next;
      reload_reg <= reload_next;
      mode_reg   <= mode_next;
      count_out  <= count_next;
      count_gray <= gray_next;
      tc         <= tc_next;
    end
  end

endmodule

`default_nettype wire
